// File: rtl/fire_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fire_pkg : shared constants for the fire-path scheduler              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fire_pkg;

  localparam int c_tag_w_def = 1;
  localparam int c_stats_w   = 16;
  localparam int c_state_w   = 2;

  localparam logic [c_state_w-1:0] c_st_run   = 2'd0;
  localparam logic [c_state_w-1:0] c_st_flush = 2'd1;
  localparam logic [c_state_w-1:0] c_st_done  = 2'd2;

  // Saturating increment for the statistics counters.
  function automatic logic [c_stats_w-1:0] sat_inc(input logic [c_stats_w-1:0] v);
    return (&v) ? v : v + {{(c_stats_w-1){1'b0}}, 1'b1};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter : round-robin grant search with its rotating pointer      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_arbiter
  import fire_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int PTR_W  = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PTR_W-1:0]   o_grant_idx,
  output logic               o_grant_any
);

  localparam logic [PTR_W:0]   c_n    = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] c_last = PTR_W'(NUM_REQ-1);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W:0]   w_cand;
  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  // Walk offsets from farthest to nearest so the nearest valid lane wins.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      w_cand = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (w_cand >= c_n) w_cand = w_cand - c_n;
      if (i_req[w_cand[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_idx   = w_cand[PTR_W-1:0];
      end
    end
  end

  assign o_grant     = w_found ? (NUM_REQ'(1) << w_idx) : '0;
  assign o_grant_idx = w_idx;
  assign o_grant_any = w_found;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (w_idx == c_last) ? '0 : w_idx + PTR_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fire_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fire_sched : fire FIFO enqueue arbiter, drain stage and step barrier |
// | Optional counters under FIFO macro FIRE_SCHED_STATS_EN. Rev 1.0      |
// +----------------------------------------------------------------------+
module fire_sched
  import fire_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = c_tag_w_def
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     fifo_enq,
  output logic [TAG_W-1:0]         fifo_in_tag,
  input  logic                     fifo_full,
  output logic                     fifo_deq,
  input  logic [TAG_W-1:0]         fifo_out_tag,
  input  logic                     fifo_empty,
  output logic                     fire_valid,
  output logic [TAG_W-1:0]         fire_tag,
  input  logic                     fire_ready,
  input  logic                     step_end,
  output logic                     step_done
`ifdef FIRE_SCHED_STATS_EN
  ,
  output logic [c_stats_w-1:0]     fire_count,
  output logic [c_stats_w-1:0]     stall_count
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   w_grant;
  logic [PTR_W-1:0]     w_idx;
  logic                 w_any;
  logic                 w_enq;
  logic                 w_deq;
  logic                 w_busy;
  logic [TAG_W-1:0]     w_tag;
  logic                 r_fire_valid;
  logic [TAG_W-1:0]     r_fire_tag;
  logic [c_state_w-1:0] r_state;
  logic [c_state_w-1:0] w_state_next;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .i_req       (req_valid),
    .i_advance   (w_enq),
    .o_grant     (w_grant),
    .o_grant_idx (w_idx),
    .o_grant_any (w_any)
  );

  // A full FIFO blocks enqueue even when a dequeue frees a slot this cycle.
  assign w_enq     = w_any & ~fifo_full & ~reset;
  assign req_ready = w_enq ? w_grant : '0;
  assign fifo_enq  = w_enq;

  always_comb begin
    w_tag = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_idx == PTR_W'(i)) w_tag = req_tag[i*TAG_W +: TAG_W];
    end
  end
  assign fifo_in_tag = w_tag;

  assign w_deq    = ~fifo_empty & (~r_fire_valid | fire_ready) & ~reset;
  assign fifo_deq = w_deq;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fire_valid <= 1'b0;
      r_fire_tag   <= '0;
    end else if (w_deq) begin
      r_fire_valid <= 1'b1;
      r_fire_tag   <= fifo_out_tag;
    end else if (fire_ready) begin
      r_fire_valid <= 1'b0;
    end
  end

  assign fire_valid = r_fire_valid;
  assign fire_tag   = r_fire_tag;

  assign w_busy = (|req_valid) | ~fifo_empty | r_fire_valid;

  always_ff @(posedge clk) begin
    if (reset) r_state <= c_st_run;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_run:   if (step_end) w_state_next = c_st_flush;
      c_st_flush: if (!w_busy)  w_state_next = c_st_done;
      c_st_done:  w_state_next = c_st_run;
      default:    w_state_next = c_st_run;
    endcase
  end

  always_comb begin
    step_done = 1'b0;
    if (r_state == c_st_done) step_done = 1'b1;
  end

`ifdef FIRE_SCHED_STATS_EN
  logic                 w_stall;
  logic [c_stats_w-1:0] r_fire_count;
  logic [c_stats_w-1:0] r_stall_count;

  assign w_stall = (|req_valid) & fifo_full;

  always_ff @(posedge clk) begin
    if (reset || r_state == c_st_done) begin
      r_fire_count  <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_enq)   r_fire_count  <= sat_inc(r_fire_count);
      if (w_stall) r_stall_count <= sat_inc(r_stall_count);
    end
  end

  assign fire_count  = r_fire_count;
  assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fire_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fire_sched : directed bench with a queue-based reference model    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fire_sched;

  localparam int N     = 4;
  localparam int TW    = 1;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*TW-1:0] req_tag = '0;
  logic [N-1:0]  req_ready;
  logic          fifo_enq;
  logic [TW-1:0] fifo_in_tag;
  logic          fifo_full;
  logic          fifo_deq;
  logic [TW-1:0] fifo_out_tag;
  logic          fifo_empty;
  logic          fire_valid;
  logic [TW-1:0] fire_tag;
  logic          fire_ready = 1'b0;
  logic          step_end = 1'b0;
  logic          step_done;
`ifdef FIRE_SCHED_STATS_EN
  logic [15:0]   fire_count;
  logic [15:0]   stall_count;
`endif

  // Environment FIFO: contents live in the model queue, status is driven from it.
  logic          full_force = 1'b0;
  int            fq_size = 0;
  logic [TW-1:0] fq_head = '0;
  assign fifo_full    = full_force | (fq_size >= DEPTH);
  assign fifo_empty   = (fq_size == 0);
  assign fifo_out_tag = fq_head;

  always #5 clk = ~clk;

  fire_sched #(.NUM_REQ(N), .TAG_W(TW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_tag      (req_tag),
    .req_ready    (req_ready),
    .fifo_enq     (fifo_enq),
    .fifo_in_tag  (fifo_in_tag),
    .fifo_full    (fifo_full),
    .fifo_deq     (fifo_deq),
    .fifo_out_tag (fifo_out_tag),
    .fifo_empty   (fifo_empty),
    .fire_valid   (fire_valid),
    .fire_tag     (fire_tag),
    .fire_ready   (fire_ready),
    .step_end     (step_end),
    .step_done    (step_done)
`ifdef FIRE_SCHED_STATS_EN
    ,
    .fire_count   (fire_count),
    .stall_count  (stall_count)
`endif
  );

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  // Reference state: 0 run, 1 flush, 2 done.
  int            m_ptr = 0;
  logic          m_fv  = 1'b0;
  logic [TW-1:0] m_ft  = '0;
  int            m_st  = 0;
  int            m_fc  = 0;
  int            m_sc  = 0;
  logic [TW-1:0] fq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int grant_of(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int g;
    bit en, dq, busy;
    g    = grant_of(req_valid, m_ptr);
    en   = !reset && !fifo_full && g >= 0;
    dq   = !reset && fq.size() > 0 && (!m_fv || fire_ready);
    busy = (req_valid != 0) || fq.size() > 0 || m_fv;
    if (reset) begin
      m_ptr = 0; m_fv = 1'b0; m_ft = '0; m_st = 0; m_fc = 0; m_sc = 0;
      fq.delete();
    end else begin
      if (m_st == 2) begin
        m_fc = 0; m_sc = 0;
      end else begin
        if (en && m_fc < 65535) m_fc++;
        if (req_valid != 0 && fifo_full && m_sc < 65535) m_sc++;
      end
      case (m_st)
        0:       if (step_end) m_st = 1;
        1:       if (!busy) m_st = 2;
        default: m_st = 0;
      endcase
      if (dq) begin
        m_ft = fq.pop_front();
        m_fv = 1'b1;
      end else if (fire_ready) begin
        m_fv = 1'b0;
      end
      if (en) begin
        fq.push_back(req_tag[g*TW +: TW]);
        m_ptr = (g + 1) % N;
      end
    end
    #1;
    fq_size = fq.size();
    fq_head = (fq.size() > 0) ? fq[0] : '0;
  end

  always @(negedge clk) begin : compare
    int g;
    bit en, dq;
    logic [N-1:0] er;
    if (armed) begin
      g  = grant_of(req_valid, m_ptr);
      en = !reset && !fifo_full && g >= 0;
      dq = !reset && !fifo_empty && (!m_fv || fire_ready);
      er = en ? (N'(1) << g) : '0;
      chk("req_ready", req_ready, er);
      chk("fifo_enq", fifo_enq, en);
      if (en) chk("fifo_in_tag", fifo_in_tag, req_tag[g*TW +: TW]);
      chk("fifo_deq", fifo_deq, dq);
      chk("fire_valid", fire_valid, m_fv);
      chk("fire_tag", fire_tag, m_ft);
      chk("step_done", step_done, m_st == 2);
`ifdef FIRE_SCHED_STATS_EN
      chk("fire_count", fire_count, m_fc);
      chk("stall_count", stall_count, m_sc);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      #3;
      if (step_done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(nm, ok, 1);
  endtask

  initial begin : stim
    int exp_g[5];
    int pulses, at;
    exp_g = '{0, 1, 2, 3, 0};

    tick();
    armed = 1'b1;
    #3;
    chk("rst_fire_valid", fire_valid, 0);
    chk("rst_step_done", step_done, 0);
    chk("rst_req_ready", req_ready, 0);
    tick();
    reset = 1'b0;

    // Fairness: lanes 0..3 carry tags 1,0,1,0.
    req_tag = 4'b0101; req_valid = 4'b1111; fire_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("fair_grant", req_ready, 1 << exp_g[i]);
      chk("fair_tag", fifo_in_tag, (exp_g[i] % 2 == 0) ? 1 : 0);
      tick();
    end

    // Full backpressure with lane 2 waiting.
    req_valid = 4'b0100; full_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("full_ready", req_ready, 0);
      chk("full_enq", fifo_enq, 0);
      tick();
    end
    full_force = 1'b0;
    #3;
    chk("full_release_grant", req_ready, 4'b0100);
    tick();

    // Drain stall.
    req_valid = '0;
    repeat (4) tick();
    #3 chk("drain_idle", fire_valid, 0);
    fire_ready = 1'b0; req_valid = 4'b0001;
    #3 chk("drain_enq1", fifo_enq, 1);
    tick();
    req_valid = 4'b0010;
    #3 chk("drain_deq_pulse", fifo_deq, 1);
    tick();
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("stall_deq", fifo_deq, 0);
      chk("stall_valid", fire_valid, 1);
      chk("stall_tag", fire_tag, 1);
      tick();
    end
    fire_ready = 1'b1;
    #3 chk("resume_deq", fifo_deq, 1);
    tick();
    #3;
    chk("resume_tag", fire_tag, 0);
    chk("resume_valid", fire_valid, 1);
    tick();
    #3;
    chk("empty_valid", fire_valid, 0);
    chk("empty_deq", fifo_deq, 0);
    tick();

    // Barrier: output reg holds one event, FIFO holds two, lane 1 pending.
    fire_ready = 1'b0; req_valid = 4'b0001;
    repeat (3) tick();
    #3;
    chk("bar_setup_valid", fire_valid, 1);
    chk("bar_setup_tag", fire_tag, 1);
    pulses = 0; at = -1;
    fire_ready = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      step_end  = (i == 0 || i == 2);
      req_valid = (i == 0) ? 4'b0010 : 4'b0000;
      #3;
      if (step_done) begin
        pulses++;
        at = i;
      end
      tick();
    end
    step_end = 1'b0;
    chk("bar_pulses", pulses, 1);
    chk("bar_offset", at, 5);

    // Reset with fire_valid high and rr_ptr at 3.
    fire_ready = 1'b0; req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    #3 chk("pre_rst_valid", fire_valid, 1);
    reset = 1'b1; req_valid = 4'b1111;
    #3;
    chk("in_rst_ready", req_ready, 0);
    chk("in_rst_enq", fifo_enq, 0);
    tick();
    reset = 1'b0;
    #3;
    chk("post_rst_valid", fire_valid, 0);
    chk("post_rst_done", step_done, 0);
    chk("post_rst_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0; fire_ready = 1'b1;

    // Close out the step, then count 5 enqueues and 2 stalls in a fresh one.
    step_end = 1'b1;
    tick();
    step_end = 1'b0;
    wait_done("clear_done_timeout");
    tick();
    req_valid = 4'b0001;
    repeat (5) tick();
    full_force = 1'b1;
    repeat (2) tick();
    full_force = 1'b0; req_valid = '0;
`ifdef FIRE_SCHED_STATS_EN
    #3;
    chk("stats_fire", fire_count, 5);
    chk("stats_stall", stall_count, 2);
`endif
    step_end = 1'b1;
    tick();
    step_end = 1'b0;
    wait_done("stats_done_timeout");
`ifdef FIRE_SCHED_STATS_EN
    chk("stats_fire_at_done", fire_count, 5);
    chk("stats_stall_at_done", stall_count, 2);
`endif
    tick();
    #3;
    chk("after_done", step_done, 0);
`ifdef FIRE_SCHED_STATS_EN
    chk("stats_fire_cleared", fire_count, 0);
    chk("stats_stall_cleared", stall_count, 0);
`endif
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
